i_fetch_unit: RTL and testbench

Instruction-fetch requester that drives the CPU side of the instruction cache: it generates sequential fetch addresses, issues single-outstanding read requests, retries on miss until hit, and queues returned instruction words in a small FIFO for the decode stage. It sits between the pipeline front end and the `i_cache_top` CPU port (address, din, rden, wren in; hit/miss, data out). Branch redirects flush queued and in-flight fetches and restart from a new address.

---
 rtl/i_fetch_unit.sv | 113 +++++++++++
 tb/tb_i_fetch_unit.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i_fetch_unit.sv
// Instruction-fetch requester: walks the PC, issues single-outstanding cache reads,
// retries misses and buffers hit words in a small FIFO for decode.
module i_fetch_unit #(
    parameter int                 DATA_WIDTH = 32,
    parameter int                 ADD_WIDTH  = 12,
    parameter logic [ADD_WIDTH-1:0] RESET_PC = '0,
    parameter int                 ADDR_STEP  = 1,
    parameter int                 FIFO_DEPTH = 4,
    parameter int                 CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  redirect_valid,
    input  logic [ADD_WIDTH-1:0]  redirect_addr,
    output logic [ADD_WIDTH-1:0]  cache_addr,
    output logic                  cache_rden,
    output logic                  cache_wren,
    output logic [DATA_WIDTH-1:0] cache_din,
    input  logic                  cache_hit_miss,
    input  logic [DATA_WIDTH-1:0] cache_data,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [DATA_WIDTH-1:0] instr_data,
    output logic [ADD_WIDTH-1:0]  instr_addr,
    output logic [CNT_WIDTH-1:0]  miss_count
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [ADD_WIDTH-1:0] STEP      = ADD_WIDTH'(ADDR_STEP);
    localparam logic [PTR_W:0]       FIFO_FULL = (PTR_W+1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0]       CNT_ONE   = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0]     PTR_ONE   = PTR_W'(1);
    localparam logic [CNT_WIDTH-1:0] MISS_ONE  = CNT_WIDTH'(1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    state_t                r_state, w_state_nxt;
    logic [ADD_WIDTH-1:0]  r_pc;
    logic [ADD_WIDTH-1:0]  r_fifo_addr [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] r_fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wptr, r_rptr;
    logic [PTR_W:0]        r_count;
    logic [CNT_WIDTH-1:0]  r_miss_count;
    logic                  w_full, w_hit, w_miss, w_pop;

    // A redirect discards any response landing in the same cycle.
    assign w_full = (r_count == FIFO_FULL);
    assign w_hit  = (r_state == S_WAIT) &&  cache_hit_miss && !redirect_valid;
    assign w_miss = (r_state == S_WAIT) && !cache_hit_miss && !redirect_valid;
    assign w_pop  = instr_valid && instr_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (!w_full) w_state_nxt = S_REQ;
            S_REQ:   w_state_nxt = S_WAIT;
            S_WAIT:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (redirect_valid) w_state_nxt = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc         <= RESET_PC;
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_count      <= '0;
            r_miss_count <= '0;
        end else if (redirect_valid) begin
            r_pc    <= redirect_addr;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_hit) r_pc <= r_pc + STEP;
            if (w_miss && r_miss_count != '1) r_miss_count <= r_miss_count + MISS_ONE;
            if (w_hit) r_wptr <= r_wptr + PTR_ONE;
            if (w_pop) r_rptr <= r_rptr + PTR_ONE;
            case ({w_hit, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is reset so the head outputs read zero while in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_fifo_addr[i] <= '0;
                r_fifo_data[i] <= '0;
            end
        end else if (w_hit) begin
            r_fifo_addr[r_wptr] <= r_pc;
            r_fifo_data[r_wptr] <= cache_data;
        end
    end

    assign cache_addr  = r_pc;
    assign cache_rden  = (r_state == S_REQ);
    assign cache_wren  = 1'b0;
    assign cache_din   = '0;
    assign instr_valid = (r_count != '0);
    assign instr_data  = r_fifo_data[r_rptr];
    assign instr_addr  = r_fifo_addr[r_rptr];
    assign miss_count  = r_miss_count;
endmodule

// File: tb/tb_i_fetch_unit.sv
// Bench for i_fetch_unit: behavioural cache model plus a scoreboard of expected
// instruction words popped as the consumer takes them.
module tb_i_fetch_unit;
    typedef struct packed { logic [11:0] a; logic [31:0] d; } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [11:0] redirect_addr = '0;
    logic [11:0] cache_addr;
    logic        cache_rden, cache_wren;
    logic [31:0] cache_din;
    logic        cache_hit_miss = 1'b0;
    logic [31:0] cache_data = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr_data;
    logic [11:0] instr_addr;
    logic [3:0]  miss_count;

    int checks = 0, failures = 0;
    exp_t exp_q[$];
    logic [11:0] rden_log[$];
    bit sb_en = 0, all_miss = 0;
    int miss_left = 0;
    logic [11:0] miss_addr = '0;

    i_fetch_unit #(.DATA_WIDTH(32), .ADD_WIDTH(12), .RESET_PC(12'h010), .ADDR_STEP(1),
                   .FIFO_DEPTH(4), .CNT_WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
        .cache_addr(cache_addr), .cache_rden(cache_rden), .cache_wren(cache_wren),
        .cache_din(cache_din), .cache_hit_miss(cache_hit_miss), .cache_data(cache_data),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_data(instr_data),
        .instr_addr(instr_addr), .miss_count(miss_count));

    always #5 clk = ~clk;

    function automatic logic [31:0] exp_d(input logic [11:0] a);
        return 32'hA5A5_0000 ^ {20'h0, a};
    endfunction

    // Cache model: answers every request on the following cycle.
    always @(posedge clk) begin
        if (cache_rden) begin
            rden_log.push_back(cache_addr);
            if (all_miss || (miss_left > 0 && cache_addr == miss_addr)) begin
                if (!all_miss) miss_left = miss_left - 1;
                cache_hit_miss <= 1'b0;
                cache_data     <= 32'h0;
            end else begin
                cache_hit_miss <= 1'b1;
                cache_data     <= exp_d(cache_addr);
            end
        end
    end

    always @(negedge clk) begin
        if (sb_en && rst_n && instr_valid && instr_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected_pop addr=%h data=%h", instr_addr, instr_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (instr_addr !== e.a || instr_data !== e.d) begin
                    failures++;
                    $display("FAIL sb_pop got=%h/%h exp=%h/%h", instr_addr, instr_data, e.a, e.d);
                end
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0; redirect_valid = 1'b0; instr_ready = 1'b0;
        sb_en = 0; all_miss = 0; miss_left = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        rden_log.delete(); exp_q.delete();
    endtask

    task automatic redirect(input logic [11:0] a);
        @(posedge clk); #1;
        redirect_valid = 1'b1; redirect_addr = a;
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        rden_log.delete();
    endtask

    task automatic wait_log(input int n, input int budget, input string name);
        for (int c = 0; c < budget && rden_log.size() < n; c++) begin
            @(posedge clk); #1;
        end
        checks++;
        if (rden_log.size() < n) begin
            failures++;
            $display("FAIL %s_timeout got=%0d requests need=%0d", name, rden_log.size(), n);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk); #1;
        checks += 6;
        if (instr_valid !== 1'b0)   begin failures++; $display("FAIL rst_valid got=%b exp=0", instr_valid); end
        if (cache_rden !== 1'b0)    begin failures++; $display("FAIL rst_rden got=%b exp=0", cache_rden); end
        if (cache_addr !== 12'h010) begin failures++; $display("FAIL rst_addr got=%h exp=010", cache_addr); end
        if (miss_count !== 4'h0)    begin failures++; $display("FAIL rst_miss got=%h exp=0", miss_count); end
        if (instr_data !== 32'h0)   begin failures++; $display("FAIL rst_idata got=%h exp=0", instr_data); end
        if (instr_addr !== 12'h0)   begin failures++; $display("FAIL rst_iaddr got=%h exp=0", instr_addr); end
        @(negedge clk);
        rst_n = 1'b1; rden_log.delete();
        #1;
        checks++;
        if (cache_rden !== 1'b0) begin failures++; $display("FAIL rst_early_rden got=%b exp=0", cache_rden); end
        @(posedge clk); #1;
        checks++;
        if (cache_rden !== 1'b1 || cache_addr !== 12'h010) begin
            failures++; $display("FAIL rst_first_req got=%b/%h exp=1/010", cache_rden, cache_addr);
        end
    endtask

    task automatic test_stream();
        do_reset();
        for (int i = 0; i < 8; i++) exp_q.push_back('{12'h010 + 12'(i), exp_d(12'h010 + 12'(i))});
        sb_en = 1; instr_ready = 1'b1;
        for (int c = 0; c < 100 && exp_q.size() != 0; c++) begin @(posedge clk); #1; end
        instr_ready = 1'b0; sb_en = 0;
        checks++;
        if (exp_q.size() != 0) begin failures++; $display("FAIL stream_drain left=%0d exp=0", exp_q.size()); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (rden_log.size() <= i || rden_log[i] !== 12'h010 + 12'(i)) begin
                failures++; $display("FAIL stream_req%0d got=%h exp=%h", i,
                                     (rden_log.size() > i) ? rden_log[i] : 12'hxxx, 12'h010 + 12'(i));
            end
        end
        checks++;
        if (miss_count !== 4'h0) begin failures++; $display("FAIL stream_miss got=%h exp=0", miss_count); end
    endtask

    task automatic test_miss_retry();
        do_reset();
        redirect(12'h020);
        miss_addr = 12'h020; miss_left = 2;
        exp_q.push_back('{12'h020, exp_d(12'h020)});
        sb_en = 1; instr_ready = 1'b1;
        wait_log(4, 60, "miss");
        instr_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (rden_log.size() <= i || rden_log[i] !== 12'h020) begin
                failures++; $display("FAIL miss_retry%0d got=%h exp=020", i,
                                     (rden_log.size() > i) ? rden_log[i] : 12'hxxx);
            end
        end
        checks += 3;
        if (rden_log.size() < 4 || rden_log[3] !== 12'h021) begin
            failures++; $display("FAIL miss_next got=%h exp=021", (rden_log.size() > 3) ? rden_log[3] : 12'hxxx);
        end
        if (miss_count !== 4'h2) begin failures++; $display("FAIL miss_count got=%h exp=2", miss_count); end
        if (exp_q.size() != 0)   begin failures++; $display("FAIL miss_push left=%0d exp=0", exp_q.size()); end
        repeat (3) @(posedge clk); #1;
        sb_en = 0; miss_left = 0;
    endtask

    task automatic test_backpressure();
        do_reset();
        repeat (40) @(posedge clk); #1;
        checks += 4;
        if (rden_log.size() != 4) begin failures++; $display("FAIL bp_reqs got=%0d exp=4", rden_log.size()); end
        if (instr_valid !== 1'b1) begin failures++; $display("FAIL bp_valid got=%b exp=1", instr_valid); end
        if (instr_addr !== 12'h010) begin failures++; $display("FAIL bp_head_addr got=%h exp=010", instr_addr); end
        if (instr_data !== exp_d(12'h010)) begin failures++; $display("FAIL bp_head_data got=%h exp=%h", instr_data, exp_d(12'h010)); end
        rden_log.delete();
        exp_q.push_back('{12'h010, exp_d(12'h010)});
        sb_en = 1; instr_ready = 1'b1;
        @(posedge clk); #1;
        instr_ready = 1'b0;
        repeat (20) @(posedge clk); #1;
        sb_en = 0;
        checks += 4;
        if (rden_log.size() != 1 || rden_log[0] !== 12'h014) begin
            failures++; $display("FAIL bp_refill reqs=%0d first=%h exp=1/014", rden_log.size(),
                                 (rden_log.size() > 0) ? rden_log[0] : 12'hxxx);
        end
        if (exp_q.size() != 0) begin failures++; $display("FAIL bp_pop left=%0d exp=0", exp_q.size()); end
        if (instr_valid !== 1'b1) begin failures++; $display("FAIL bp_valid2 got=%b exp=1", instr_valid); end
        if (instr_addr !== 12'h011) begin failures++; $display("FAIL bp_head2 got=%h exp=011", instr_addr); end
    endtask

    task automatic test_redirect_wait();
        for (int mode = 0; mode < 2; mode++) begin
            logic [3:0] mc;
            do_reset();
            redirect(12'h005);
            if (mode == 1) begin miss_addr = 12'h005; miss_left = 1; end
            for (int c = 0; c < 20 && !cache_rden; c++) begin @(posedge clk); #1; end
            checks++;
            if (cache_rden !== 1'b1 || cache_addr !== 12'h005) begin
                failures++; $display("FAIL redir_req%0d got=%b/%h exp=1/005", mode, cache_rden, cache_addr);
            end
            mc = miss_count;
            @(posedge clk); #1;
            redirect_valid = 1'b1; redirect_addr = 12'h300;
            @(posedge clk); #1;
            redirect_valid = 1'b0;
            checks += 3;
            if (instr_valid !== 1'b0) begin failures++; $display("FAIL redir_valid%0d got=%b exp=0", mode, instr_valid); end
            if (miss_count !== mc)    begin failures++; $display("FAIL redir_miss%0d got=%h exp=%h", mode, miss_count, mc); end
            if (cache_rden !== 1'b0)  begin failures++; $display("FAIL redir_rden%0d got=%b exp=0", mode, cache_rden); end
            @(posedge clk); #1;
            checks++;
            if (cache_rden !== 1'b1 || cache_addr !== 12'h300) begin
                failures++; $display("FAIL redir_next%0d got=%b/%h exp=1/300", mode, cache_rden, cache_addr);
            end
            miss_left = 0;
        end
    endtask

    task automatic test_wrap();
        do_reset();
        redirect(12'hFFF);
        exp_q.push_back('{12'hFFF, exp_d(12'hFFF)});
        exp_q.push_back('{12'h000, exp_d(12'h000)});
        sb_en = 1; instr_ready = 1'b1;
        for (int c = 0; c < 40 && exp_q.size() != 0; c++) begin @(posedge clk); #1; end
        instr_ready = 1'b0; sb_en = 0;
        checks += 2;
        if (exp_q.size() != 0) begin failures++; $display("FAIL wrap_drain left=%0d exp=0", exp_q.size()); end
        if (rden_log.size() < 2 || rden_log[0] !== 12'hFFF || rden_log[1] !== 12'h000) begin
            failures++; $display("FAIL wrap_addr got=%h,%h exp=fff,000",
                                 (rden_log.size() > 0) ? rden_log[0] : 12'hxxx,
                                 (rden_log.size() > 1) ? rden_log[1] : 12'hxxx);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        all_miss = 1;
        repeat (70) @(posedge clk); #1;
        all_miss = 0;
        checks += 2;
        if (rden_log.size() < 20) begin failures++; $display("FAIL sat_reqs got=%0d exp>=20", rden_log.size()); end
        if (miss_count !== 4'hF)  begin failures++; $display("FAIL sat_count got=%h exp=f", miss_count); end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int c = 0; c < 40 && !(cache_rden && rden_log.size() == 3); c++) begin @(posedge clk); #1; end
        checks++;
        if (!(cache_rden && instr_valid)) begin
            failures++; $display("FAIL arst_setup rden=%b valid=%b exp=1/1", cache_rden, instr_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks += 3;
        if (instr_valid !== 1'b0)   begin failures++; $display("FAIL arst_valid got=%b exp=0", instr_valid); end
        if (cache_rden !== 1'b0)    begin failures++; $display("FAIL arst_rden got=%b exp=0", cache_rden); end
        if (cache_addr !== 12'h010) begin failures++; $display("FAIL arst_addr got=%h exp=010", cache_addr); end
        @(negedge clk);
        rst_n = 1'b1; rden_log.delete();
        @(posedge clk); #1;
        checks += 2;
        if (cache_rden !== 1'b1 || cache_addr !== 12'h010) begin
            failures++; $display("FAIL arst_restart got=%b/%h exp=1/010", cache_rden, cache_addr);
        end
        if (instr_valid !== 1'b0) begin failures++; $display("FAIL arst_empty got=%b exp=0", instr_valid); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_miss_retry();
        test_backpressure();
        test_redirect_wait();
        test_wrap();
        test_saturation();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
endmodule
